// File: rtl/frame_buf_sched.sv
// Ping-pong display scheduler: raster counters, one-hot frame-mux selects, pixel read address
// and frame-boundary buffer swaps. Optional FrameCount output when FRAME_CNT_EN is defined.
module frame_buf_sched #(
  parameter int H_ACTIVE = 8,
  parameter int H_BLANK  = 2,
  parameter int V_ACTIVE = 8,
  parameter int V_BLANK  = 2,
  parameter int ADDR_W   = 6
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              WrDone,
  output logic              SelBuf0,
  output logic              SelBlank,
  output logic              SelBuf1,
  output logic [ADDR_W-1:0] PixAddr,
  output logic              WrBuf,
  output logic              SwapAck,
  output logic              FrameStart,
`ifdef FRAME_CNT_EN
  output logic [15:0]       FrameCount,
`endif
  output logic              Overrun
);

  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int V_TOTAL = V_ACTIVE + V_BLANK;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);

  typedef enum logic {IDLE, DISPLAY} state_t;

  state_t      state, state_nx;
  logic [HW-1:0] hcnt, h_nx;
  logic [VW-1:0] vcnt, v_nx;
  logic        front, front_nx;
  logic        pending, pending_nx;
  logic        overrun_nx;
  logic        at_b, swap, active_nx;
  logic [ADDR_W-1:0] pix_nx;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Outputs are registered from the next counter/state values so they line up
  // with the counter value held in the same cycle.
  always_comb begin
    h_nx       = hcnt;
    v_nx       = vcnt;
    state_nx   = state;
    front_nx   = front;
    pending_nx = pending;
    overrun_nx = Overrun;
    at_b       = (hcnt == H_LAST) && (vcnt == V_LAST);
    swap       = at_b && (pending || WrDone);

    if (hcnt == H_LAST) begin
      h_nx = '0;
      v_nx = (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
    end else begin
      h_nx = hcnt + 1'b1;
    end

    if (WrDone && pending) overrun_nx = 1'b1;

    if (swap) begin
      front_nx   = ~front;
      pending_nx = 1'b0;
      if (state == IDLE) state_nx = DISPLAY;
    end else if (WrDone && !at_b) begin
      pending_nx = 1'b1;
    end

    active_nx = (h_nx < H_ACT) && (v_nx < V_ACT) && (state_nx == DISPLAY);
    pix_nx    = active_nx ? (ADDR_W'(v_nx) * ADDR_W'(H_ACTIVE) + ADDR_W'(h_nx)) : '0;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hcnt       <= '0;
      vcnt       <= '0;
      front      <= 1'b0;
      pending    <= 1'b0;
      SelBuf0    <= 1'b0;
      SelBlank   <= 1'b1;
      SelBuf1    <= 1'b0;
      PixAddr    <= '0;
      WrBuf      <= 1'b1;
      SwapAck    <= 1'b0;
      FrameStart <= 1'b0;
      Overrun    <= 1'b0;
    end else begin
      hcnt       <= h_nx;
      vcnt       <= v_nx;
      front      <= front_nx;
      pending    <= pending_nx;
      SelBuf0    <= active_nx && !front_nx;
      SelBlank   <= !active_nx;
      SelBuf1    <= active_nx && front_nx;
      PixAddr    <= pix_nx;
      WrBuf      <= !front_nx;
      SwapAck    <= swap;
      FrameStart <= (h_nx == '0) && (v_nx == '0);
      Overrun    <= overrun_nx;
    end
  end

`ifdef FRAME_CNT_EN
  // Counts every frame boundary, whether or not a swap happened.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)     FrameCount <= '0;
    else if (at_b) FrameCount <= FrameCount + 16'd1;
  end
`endif

endmodule

// File: tb/tb_frame_buf_sched.sv
// Bench for frame_buf_sched on a 6x4 raster (4x3 active, 24-cycle frame); a cycle model
// feeds a scoreboard queue and a scenario table supplies end-of-run expectations.
module tb_frame_buf_sched;

  localparam int HA = 4, HB = 2, VA = 3, VB = 1, AW = 6;
  localparam int HT = HA + HB, VT = VA + VB, FT = HT * VT;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          WrDone = 1'b0;
  logic          SelBuf0, SelBlank, SelBuf1, WrBuf, SwapAck, FrameStart, Overrun;
  logic [AW-1:0] PixAddr;
`ifdef FRAME_CNT_EN
  logic [15:0]   FrameCount;
`endif

  frame_buf_sched #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB), .ADDR_W(AW)
  ) dut (
    .Clk(Clk), .Reset(Reset), .WrDone(WrDone),
    .SelBuf0(SelBuf0), .SelBlank(SelBlank), .SelBuf1(SelBuf1),
    .PixAddr(PixAddr), .WrBuf(WrBuf), .SwapAck(SwapAck), .FrameStart(FrameStart),
`ifdef FRAME_CNT_EN
    .FrameCount(FrameCount),
`endif
    .Overrun(Overrun)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic          b0, blank, b1, wrbuf, ack, fs, ovr;
    logic [AW-1:0] addr;
  } expect_t;

  expect_t q[$];
  int checks = 0;
  int failures = 0;

  int m_n;
  bit m_front, m_display, m_pending, m_overrun, m_ack;
  int ack_count, ack_first;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d actual=%0d required=%0d", name, m_n, act, req);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".SelBlank"}, int'(SelBlank), 1);
    check({tag, ".SelBuf0"}, int'(SelBuf0), 0);
    check({tag, ".SelBuf1"}, int'(SelBuf1), 0);
    check({tag, ".PixAddr"}, int'(PixAddr), 0);
    check({tag, ".WrBuf"}, int'(WrBuf), 1);
    check({tag, ".SwapAck"}, int'(SwapAck), 0);
    check({tag, ".FrameStart"}, int'(FrameStart), 0);
    check({tag, ".Overrun"}, int'(Overrun), 0);
  endtask

  task automatic reset_dut();
    Reset = 1'b1;
    WrDone = 1'b0;
    @(posedge Clk);
    #1;
    check_reset_values("reset");
    @(negedge Clk);
    Reset = 1'b0;
    q.delete();
    m_n = 0; m_front = 0; m_display = 0; m_pending = 0; m_overrun = 0; m_ack = 0;
    ack_count = 0; ack_first = -1;
  endtask

  task automatic check_output();
    expect_t e;
    if (q.size() == 0) begin
      check("scoreboard_empty", 1, 0);
      return;
    end
    e = q.pop_front();
    check("SelBuf0", int'(SelBuf0), int'(e.b0));
    check("SelBlank", int'(SelBlank), int'(e.blank));
    check("SelBuf1", int'(SelBuf1), int'(e.b1));
    check("PixAddr", int'(PixAddr), int'(e.addr));
    check("WrBuf", int'(WrBuf), int'(e.wrbuf));
    check("SwapAck", int'(SwapAck), int'(e.ack));
    check("FrameStart", int'(FrameStart), int'(e.fs));
    check("Overrun", int'(Overrun), int'(e.ovr));
    check("one_hot", $countones({SelBuf0, SelBlank, SelBuf1}), 1);
    if (SwapAck) begin
      ack_count++;
      if (ack_first < 0) ack_first = m_n;
    end
  endtask

  // Drive WrDone for the current cycle, advance the model one edge, then compare.
  task automatic apply_stimulus(input logic wd);
    bit at_b, swap, act;
    int h, v;
    expect_t e;
    WrDone = wd;
    at_b = (m_n % FT) == FT - 1;
    swap = at_b && (m_pending || wd);
    if (wd && m_pending) m_overrun = 1;
    if (swap) begin
      m_front = !m_front;
      m_display = 1;
      m_pending = 0;
    end else if (wd && !at_b) begin
      m_pending = 1;
    end
    m_ack = swap;
    m_n++;
    h = m_n % HT;
    v = (m_n / HT) % VT;
    act = m_display && (h < HA) && (v < VA);
    e.b0 = act && !m_front;
    e.b1 = act && m_front;
    e.blank = !act;
    e.addr = act ? AW'(v * HA + h) : '0;
    e.wrbuf = !m_front;
    e.ack = m_ack;
    e.fs = (m_n % FT) == 0;
    e.ovr = m_overrun;
    q.push_back(e);
    @(posedge Clk);
    #1;
    WrDone = 1'b0;
    check_output();
  endtask

  typedef struct {
    string name;
    int    wr_a, wr_b;
    int    first_ack, n_acks;
    bit    wrbuf_end, overrun_end;
  } scen_t;

  scen_t scen[6];

  initial begin
    scen[0] = '{"idle",          -1, -1, -1, 0, 1'b1, 1'b0};
    scen[1] = '{"single_swap",    5, -1, 24, 1, 1'b0, 1'b0};
    scen[2] = '{"double_swap",    5, 30, 24, 2, 1'b1, 1'b0};
    scen[3] = '{"overrun",        5, 10, 24, 1, 1'b0, 1'b1};
    scen[4] = '{"wr_at_boundary", 23, -1, 24, 1, 1'b0, 1'b0};
    scen[5] = '{"pending_at_b",   5, 23, 24, 1, 1'b0, 1'b1};

    for (int s = 0; s < 6; s++) begin
      reset_dut();
      for (int c = 0; c < 50; c++)
        apply_stimulus(c == scen[s].wr_a || c == scen[s].wr_b);
      check({scen[s].name, ".first_ack"}, ack_first, scen[s].first_ack);
      check({scen[s].name, ".n_acks"}, ack_count, scen[s].n_acks);
      check({scen[s].name, ".WrBuf_end"}, int'(WrBuf), int'(scen[s].wrbuf_end));
      check({scen[s].name, ".Overrun_end"}, int'(Overrun), int'(scen[s].overrun_end));
    end

    // Asynchronous reset mid-frame while displaying (HCnt=2, VCnt=1 of frame 2).
    reset_dut();
    for (int c = 0; c < 32; c++) apply_stimulus(c == 5);
    check("pre_reset.SelBuf1", int'(SelBuf1), 1);
    check("pre_reset.PixAddr", int'(PixAddr), 6);
    #2;
    Reset = 1'b1;
    #1;
    check_reset_values("async_reset");
    reset_dut();
    for (int c = 0; c < 50; c++) apply_stimulus(c == 30);
    check("post_reset.first_ack", ack_first, 48);

`ifdef FRAME_CNT_EN
    reset_dut();
    check("FrameCount_reset", int'(FrameCount), 0);
    for (int c = 0; c < 72; c++) apply_stimulus(1'b0);
    check("FrameCount_72", int'(FrameCount), 3);
    Reset = 1'b1;
    #1;
    check("FrameCount_after_reset", int'(FrameCount), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
